// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types and helpers for the memory-side arbiter and its round-robin picker.
// The index helper is fixed at the widest supported port count (8).
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  localparam int MAX_PORTS = 8;

  // Encodes a one-hot vector; narrower vectors are zero-extended by the caller.
  function automatic logic [2:0] onehot_to_index(input logic [MAX_PORTS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Arbiter <-> cacheline adapter bus: registered strobes/address/data out,
// completion pulse and read line back.
interface mem_arbiter_rr_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);

  logic                  mem_read_o;
  logic                  mem_write_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [LINE_WIDTH-1:0] mem_wdata_o;
  logic                  mem_resp_i;
  logic [LINE_WIDTH-1:0] mem_rdata_i;

  modport master (
    output mem_read_o,
    output mem_write_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_resp_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_read_o,
    input  mem_write_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_resp_i,
    output mem_rdata_i
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational requester picker: lowest index at or after the pointer (wrapping),
// or plain lowest index when rr_mode is low.
module rr_picker #(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  input  logic                 rr_mode,
  output logic [NUM_PORTS-1:0] win,
  output logic                 vld
);

  localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

  logic [NUM_PORTS-1:0] mask;
  logic [NUM_PORTS-1:0] req_hi;
  logic [NUM_PORTS-1:0] pick;

  // Requests at or above the pointer take precedence; if none, wrap to the full set.
  always_comb begin
    mask = '1;
    if (rr_mode) mask = mask << ptr;
    req_hi = req & mask;
    pick   = (|req_hi) ? req_hi : req;
    win    = pick & (~pick + ONE);
    vld    = |req;
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port arbiter in front of the single cacheline adapter: one transaction at a
// time, registered memory-side outputs, response routed to the owning port only.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int ARB_MODE   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            port_read_i,
  input  logic [NUM_PORTS-1:0]            port_write_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr_i,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0] port_wdata_i,
  output logic [LINE_WIDTH-1:0]           port_rdata_o,
  output logic [NUM_PORTS-1:0]            port_resp_o,
  output logic [NUM_PORTS-1:0]            grant_o,
  output logic                            err_o,
  mem_arbiter_rr_if.master                mif
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  arb_state_e            state;
  logic [PTR_W-1:0]      ptr;
  logic [NUM_PORTS-1:0]  grant_q;
  logic                  rd_q;
  logic                  wr_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;

  logic [NUM_PORTS-1:0]  win_oh;
  logic                  win_vld;
  logic [2:0]            win_idx;
  logic [PTR_W-1:0]      ptr_next;
  logic                  sel_rd;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LINE_WIDTH-1:0] sel_wdata;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_picker (
    .req     (port_read_i | port_write_i),
    .ptr     (ptr),
    .rr_mode (ARB_MODE == ARB_RR),
    .win     (win_oh),
    .vld     (win_vld)
  );

  assign win_idx = onehot_to_index(8'(win_oh));

  always_comb begin
    if (int'(win_idx) == NUM_PORTS - 1) ptr_next = '0;
    else                                ptr_next = PTR_W'(win_idx + 3'd1);
  end

  always_comb begin
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_oh[i]) begin
        sel_rd    = port_read_i[i];
        sel_wr    = port_write_i[i];
        sel_addr  = port_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = port_wdata_i[i*LINE_WIDTH +: LINE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant_q <= win_oh;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            // A simultaneous read+write resolves to the write and is flagged.
            wr_q    <= sel_wr;
            rd_q    <= sel_rd & ~sel_wr;
            if (sel_rd && sel_wr) err_q <= 1'b1;
            if (ARB_MODE == ARB_RR) ptr <= ptr_next;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (mif.mem_resp_i) begin
            grant_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_o         = grant_q;
  assign err_o           = err_q;
  assign mif.mem_read_o  = rd_q;
  assign mif.mem_write_o = wr_q;
  assign mif.mem_addr_o  = addr_q;
  assign mif.mem_wdata_o = wdata_q;
  assign port_rdata_o    = mif.mem_rdata_i;
  assign port_resp_o     = (state == BUSY && mif.mem_resp_i) ? grant_q : '0;

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-port arbiter between cache-side requesters (icache, dcache, prefetcher, ...) and the single cacheline adapter.
- Selects one requester per transaction, in fixed-priority or round-robin mode.
- Latches the winner's address, write data and operation into registers, so memory-side outputs are registered.
- Routes the adapter's response pulse back to the granted port only.

Parameters:
NUM_PORTS, 2, number of requesters (2..8)
ADDR_WIDTH, 32, byte address width
LINE_WIDTH, 256, cacheline data width
ARB_MODE, 1, 0 = fixed priority (port 0 highest), 1 = round-robin

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
port_read_i  in  NUM_PORTS  per-port read request
port_write_i  in  NUM_PORTS  per-port write request
port_addr_i  in  NUM_PORTS*ADDR_WIDTH  per-port address, packed, port 0 in LSBs
port_wdata_i  in  NUM_PORTS*LINE_WIDTH  per-port write line, packed
port_rdata_o  out  LINE_WIDTH  read line, broadcast to all ports
port_resp_o  out  NUM_PORTS  per-port completion pulse
grant_o  out  NUM_PORTS  one-hot current owner, 0 when idle
err_o  out  1  sticky: a port raised read and write together
mem_resp_i  in  1  adapter completion
mem_rdata_i  in  LINE_WIDTH  adapter read line
mem_addr_o  out  ADDR_WIDTH  registered address
mem_wdata_o  out  LINE_WIDTH  registered write line
mem_read_o  out  1  adapter read strobe
mem_write_o  out  1  adapter write strobe

Behaviour:
- Reset (rst low, takes effect immediately, including mid-transaction):
  - state = IDLE; RR pointer = 0.
  - grant_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, err_o all 0.
  - port_resp_o = 0.
  - Any in-flight adapter transaction is abandoned; no resp is forwarded.
- A port requests when port_read_i[i] or port_write_i[i] is high. It must hold the request until its port_resp_o[i].
- States: IDLE, BUSY.
- IDLE:
  - If any request is present: pick winner w, register grant one-hot, latch addr[w], wdata[w] and the operation, then go to BUSY.
  - Otherwise stay in IDLE.
- Winner selection:
  - ARB_MODE 0: lowest index.
  - ARB_MODE 1: first requesting index at or after the pointer, wrapping NUM_PORTS-1 -> 0. At grant, pointer <= (w+1) mod NUM_PORTS.
  - Pointer is unchanged in mode 0.
- BUSY:
  - mem_read_o = latched read; mem_write_o = latched write; mem_addr_o and mem_wdata_o are the latched values.
  - port_resp_o[w] = mem_resp_i combinationally; all other bits 0.
  - On mem_resp_i: go to IDLE; grant_o clears the next cycle.
- port_rdata_o = mem_rdata_i always (combinational); only valid on the resp cycle.
- Read and write both high on the winner: write wins, err_o set (sticky until reset).
- Latency:
  - Request sampled in IDLE at cycle t -> mem strobe high at t+1.
  - Resp at cycle r -> port_resp high at r; IDLE at r+1; next strobe no earlier than r+2 (one mandatory bubble).
- Boundary conditions:
  - Request dropped by the port while BUSY: ignored; the transaction completes on latched values; the resp pulse still goes to that port.
  - mem_resp_i in IDLE: ignored; no port_resp.
  - Simultaneous requests from all ports, mode 1: each port is served within NUM_PORTS grants (no starvation).
  - A port's new request on the cycle after its own resp competes normally; in mode 1 it has lowest priority.
- mem_addr_o and mem_wdata_o hold their last values in IDLE; they are don't-care while strobes are low.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, BUSY), ARB_FIXED = 0, ARB_RR = 1, function onehot_to_index.
- One combinational sub-module rr_picker (NUM_PORTS, req vector, pointer, mode -> one-hot winner, valid). Reused later by the prefetch queue.

Test Plan:
- Reset mid-BUSY: port0 read granted, rst low at cycle 3 -> all outputs 0 that cycle; after release, no port_resp when the stale mem_resp_i arrives.
- Single read: NUM_PORTS=2, port1 read addr 0x0000_1040 at t=0; mem_resp_i at t=5 with rdata 0xA5..A5 -> mem_read_o high t=1..5, mem_addr_o=0x1040, port_resp_o=2'b10 at t=5 only, grant_o=0 at t=6.
- Round-robin: NUM_PORTS=4, ports 0-3 request continuously, 1-cycle adapter -> grant order 0,1,2,3,0; strobe rises every 3 cycles.
- Fixed priority: ARB_MODE=0, ports 0 and 2 request continuously -> port 2 never granted; after port 0 drops, port 2 granted at the next IDLE.
- Write path and error: port0 read and write both high, wdata=0x1234... -> mem_write_o=1, mem_read_o=0, mem_wdata_o matches, err_o=1 and stays high.
- Dropped request: port1 deasserts at BUSY cycle 2 -> strobes persist until mem_resp_i; port_resp_o[1] pulses.
